// File: rtl/excecao_vector_reader.sv
// Exception-entry sequencer: saves EPC = PC-4, reads the cause vector byte
// from memory and loads it into PC. Optional causa_reg: EXC_CAUSE_REG_EN.
//
// Ports:
//   clk, reset (async, active-low)
//   req_excecao, causa[1:0], valorPC[31:0], mem_data_in[31:0]
//   mem_addr[31:0], mem_rd, busy
//   pc_out[31:0], pc_wr, epc_out[31:0], epc_wr
//   done, causa_err
//   causa_reg[1:0] (only when EXC_CAUSE_REG_EN is defined)
module excecao_vector_reader #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter logic [7:0]  VEC_OPCODE   = 8'd253,
  parameter logic [7:0]  VEC_OVERFLOW = 8'd254,
  parameter logic [7:0]  VEC_DIVZERO  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_excecao,
  input  logic [1:0]  causa,
  input  logic [31:0] valorPC,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        busy,
  output logic [31:0] pc_out,
  output logic        pc_wr,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic        done,
`ifdef EXC_CAUSE_REG_EN
  output logic [1:0]  causa_reg,
`endif
  output logic        causa_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  cause;
  logic [31:0] epc_reg;

  // Only the low byte of the memory word carries the vector.
  logic unused_hi;
  assign unused_hi = ^mem_data_in[31:8];

  function automatic logic [7:0] vec_of(input logic [1:0] c);
    logic [7:0] v;
    v = 8'd0;
    unique case (1'b1)
      (c == 2'b01): v = VEC_OPCODE;
      (c == 2'b10): v = VEC_OVERFLOW;
      (c == 2'b11): v = VEC_DIVZERO;
      default:      v = 8'd0;
    endcase
    return v;
  endfunction

  // Outputs are registered: each branch sets what the next
  // state must present, so they line up with the state cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cause     <= 2'b00;
      epc_reg   <= 32'd0;
      mem_addr  <= 32'd0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      pc_out    <= 32'd0;
      pc_wr     <= 1'b0;
      epc_out   <= 32'd0;
      epc_wr    <= 1'b0;
      done      <= 1'b0;
      causa_err <= 1'b0;
`ifdef EXC_CAUSE_REG_EN
      causa_reg <= 2'b00;
`endif
    end else begin
      mem_rd    <= 1'b0;
      pc_wr     <= 1'b0;
      epc_wr    <= 1'b0;
      done      <= 1'b0;
      causa_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_excecao) begin
            if (causa != 2'b00) begin
              cause    <= causa;
              epc_reg  <= valorPC - 32'd4;
              busy     <= 1'b1;
              mem_rd   <= 1'b1;
              mem_addr <= {24'd0, vec_of(causa)};
              state    <= S_ADDR;
            end else begin
              causa_err <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          cnt   <= LAT;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Data is valid in the last wait cycle; grab it on its edge.
          if (cnt <= 4'd1) begin
            cnt     <= 4'd0;
            pc_out  <= {24'd0, mem_data_in[7:0]};
            pc_wr   <= 1'b1;
            epc_out <= epc_reg;
            epc_wr  <= 1'b1;
`ifdef EXC_CAUSE_REG_EN
            causa_reg <= cause;
`endif
            state   <= S_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_LOAD: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excecao_vector_reader.sv
// Bench for excecao_vector_reader: two instances (latency 1 and 4),
// latency-accurate memory model, scoreboard of expected PC/EPC writes.
module tb_excecao_vector_reader;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req[2];
  logic [1:0]  causa[2];
  logic [31:0] pcin[2];
  logic [31:0] mdata[2];
  logic [31:0] mem_addr[2];
  logic        mem_rd[2];
  logic        busy[2];
  logic [31:0] pc_out[2];
  logic        pc_wr[2];
  logic [31:0] epc_out[2];
  logic        epc_wr[2];
  logic        done[2];
  logic        causa_err[2];
  logic [1:0]  creg[2];

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] d;
    d = 32'hFFFF_FF5A;
    if (a == 32'd253) d = 32'hABCD_EF12;
    if (a == 32'd254) d = 32'h0000_0080;
    if (a == 32'd255) d = 32'h1234_56C4;
    return d;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ML = (g == 0) ? 1 : 4;
    int          cnt = 0;
    logic [31:0] paddr = 32'd0;

    excecao_vector_reader #(.MEM_LATENCY(ML)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_excecao (req[g]),
      .causa       (causa[g]),
      .valorPC     (pcin[g]),
      .mem_data_in (mdata[g]),
      .mem_addr    (mem_addr[g]),
      .mem_rd      (mem_rd[g]),
      .busy        (busy[g]),
      .pc_out      (pc_out[g]),
      .pc_wr       (pc_wr[g]),
      .epc_out     (epc_out[g]),
      .epc_wr      (epc_wr[g]),
      .done        (done[g]),
`ifdef EXC_CAUSE_REG_EN
      .causa_reg   (creg[g]),
`endif
      .causa_err   (causa_err[g])
    );

`ifndef EXC_CAUSE_REG_EN
    assign creg[g] = 2'b00;
`endif

    // Read data is valid only in the cycle ML cycles after the read strobe.
    always @(posedge clk) begin
      if (mem_rd[g]) begin
        if (ML == 1) begin
          mdata[g] <= rom(mem_addr[g]);
        end else begin
          mdata[g] <= 32'hFFFF_FF5A;
          cnt      <= ML - 1;
          paddr    <= mem_addr[g];
        end
      end else if (cnt > 1) begin
        cnt      <= cnt - 1;
        mdata[g] <= 32'hFFFF_FF5A;
      end else if (cnt == 1) begin
        cnt      <= 0;
        mdata[g] <= rom(paddr);
      end else begin
        mdata[g] <= 32'hFFFF_FF5A;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_pulse(input int i, input logic [1:0] c,
                           input logic [31:0] pc);
    req[i]   = 1'b1;
    causa[i] = c;
    pcin[i]  = pc;
    step();
    req[i]   = 1'b0;
  endtask

  task automatic all_zero(input int i, input string tag);
    chk({tag, "_addr"}, mem_addr[i], 32'd0);
    chk({tag, "_rd"}, {31'd0, mem_rd[i]}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy[i]}, 32'd0);
    chk({tag, "_pc"}, pc_out[i], 32'd0);
    chk({tag, "_pcwr"}, {31'd0, pc_wr[i]}, 32'd0);
    chk({tag, "_epc"}, epc_out[i], 32'd0);
    chk({tag, "_epcwr"}, {31'd0, epc_wr[i]}, 32'd0);
    chk({tag, "_done"}, {31'd0, done[i]}, 32'd0);
    chk({tag, "_err"}, {31'd0, causa_err[i]}, 32'd0);
  endtask

  // Scoreboard: each PC write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (pc_wr[i]) begin
          exp_t e;
          int   n;
          n = (i == 0) ? q0.size() : q1.size();
          chk($sformatf("sb%0d_pending", i), (n > 0) ? 32'd1 : 32'd0, 32'd1);
          if (n > 0) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("sb%0d_pc", i), pc_out[i], e.pc);
            chk($sformatf("sb%0d_epc", i), epc_out[i], e.epc);
            chk($sformatf("sb%0d_epcwr", i), {31'd0, epc_wr[i]}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int lat;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i]   = 1'b0;
      causa[i] = 2'b00;
      pcin[i]  = 32'd0;
    end
    step();
    step();
    all_zero(0, "rst0");
    all_zero(1, "rst1");
    reset = 1'b1;
    repeat (3) step();
    all_zero(0, "idle0");
    reset = 1'b0;
    #1;
    all_zero(0, "rstidle0");
    reset = 1'b1;
    step();

    // Overflow, latency 1
    q0.push_back('{32'h80, 32'h20});
    req_pulse(0, 2'b10, 32'h24);
    chk("ovf_rd", {31'd0, mem_rd[0]}, 32'd1);
    chk("ovf_addr", mem_addr[0], 32'd254);
    chk("ovf_busy1", {31'd0, busy[0]}, 32'd1);
    step();
    chk("ovf_rd2", {31'd0, mem_rd[0]}, 32'd0);
    chk("ovf_busy2", {31'd0, busy[0]}, 32'd1);
    chk("ovf_pcwr2", {31'd0, pc_wr[0]}, 32'd0);
    step();
    chk("ovf_pcwr3", {31'd0, pc_wr[0]}, 32'd1);
    chk("ovf_epcwr3", {31'd0, epc_wr[0]}, 32'd1);
    step();
    chk("ovf_done4", {31'd0, done[0]}, 32'd1);
    chk("ovf_busy4", {31'd0, busy[0]}, 32'd0);
    chk("ovf_pcwr4", {31'd0, pc_wr[0]}, 32'd0);
    chk("ovf_pchold", pc_out[0], 32'h80);
    step();
    chk("ovf_done5", {31'd0, done[0]}, 32'd0);

    // Invalid opcode: upper data bits ignored
    q0.push_back('{32'h12, 32'h0FFC});
    req_pulse(0, 2'b01, 32'h1000);
    chk("opc_addr", mem_addr[0], 32'd253);
    repeat (2) step();
    chk("opc_pc", pc_out[0], 32'h12);
    repeat (2) step();

    // Divide by zero
    q0.push_back('{32'hC4, 32'h1C});
    req_pulse(0, 2'b11, 32'h20);
    chk("dz_addr", mem_addr[0], 32'd255);
    repeat (4) step();

    // Rejected cause
    req[0]   = 1'b1;
    causa[0] = 2'b00;
    pcin[0]  = 32'h40;
    step();
    req[0] = 1'b0;
    chk("rej_err", {31'd0, causa_err[0]}, 32'd1);
    chk("rej_busy", {31'd0, busy[0]}, 32'd0);
    chk("rej_rd", {31'd0, mem_rd[0]}, 32'd0);
    step();
    chk("rej_err2", {31'd0, causa_err[0]}, 32'd0);
    chk("rej_busy2", {31'd0, busy[0]}, 32'd0);

    // Collision during WAIT, then request held through DONE
    q0.push_back('{32'h80, 32'hFC});
    req_pulse(0, 2'b10, 32'h100);
    step();
    req[0]   = 1'b1;
    causa[0] = 2'b11;
    pcin[0]  = 32'h500;
    step();
    chk("col_pcwr", {31'd0, pc_wr[0]}, 32'd1);
    chk("col_addr", mem_addr[0], 32'd254);
    causa[0] = 2'b01;
    pcin[0]  = 32'h600;
    step();
    chk("col_done", {31'd0, done[0]}, 32'd1);
    q0.push_back('{32'h12, 32'h5FC});
    step();
    chk("dn_busy", {31'd0, busy[0]}, 32'd0);
    chk("dn_rd", {31'd0, mem_rd[0]}, 32'd0);
    step();
    req[0] = 1'b0;
    chk("dn_rd2", {31'd0, mem_rd[0]}, 32'd1);
    chk("dn_addr", mem_addr[0], 32'd253);
    repeat (3) step();
    chk("dn_done", {31'd0, done[0]}, 32'd1);
    step();

    // Latency 4 with PC wrap
    q1.push_back('{32'h80, 32'hFFFF_FFFC});
    req_pulse(1, 2'b10, 32'h0);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (pc_wr[1] && lat == 0) lat = k;
      step();
    end
    chk("lat4_cycles", lat, 32'd6);

    // Reset during WAIT
    req_pulse(1, 2'b11, 32'h80);
    step();
    step();
    chk("mid_busy", {31'd0, busy[1]}, 32'd1);
    reset = 1'b0;
    #1;
    all_zero(1, "mid1");
    repeat (3) step();
    chk("mid_pcwr", {31'd0, pc_wr[1]}, 32'd0);
    reset = 1'b1;
    step();
    q1.push_back('{32'h12, 32'h7C});
    req_pulse(1, 2'b01, 32'h80);
    repeat (5) step();
    chk("rec_pcwr", {31'd0, pc_wr[1]}, 32'd1);
    step();
    chk("rec_done", {31'd0, done[1]}, 32'd1);
    step();

    chk("sb0_empty", q0.size(), 32'd0);
    chk("sb1_empty", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/excecao_vector_reader.md
Name: excecao_vector_reader

Overview:
- Exception-entry sequencer for the multicycle datapath; it is the consumer of the exception-vector addresses 253/254/255 that the memory address mux can select.
- On an exception request it does the following:
  - captures EPC = PC - 4;
  - issues a memory read at the vector address for the cause;
  - waits out the memory latency;
  - loads the zero-extended vector byte into PC.
- The control unit hands over the memory address/read path while busy is high.

Parameters:
- MEM_LATENCY, 1: cycles between the read request cycle and valid mem_data_in (1..15).
- VEC_OPCODE, 253: vector address for invalid opcode.
- VEC_OVERFLOW, 254: vector address for arithmetic overflow.
- VEC_DIVZERO, 255: vector address for divide by zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_excecao  in  1  exception request, sampled when idle.
- causa  in  2  01 opcode, 10 overflow, 11 div-by-zero, 00 invalid.
- valorPC  in  32  current PC (already incremented by 4).
- mem_data_in  in  32  memory read data; vector byte is in [7:0].
- mem_addr  out  32  memory address while busy.
- mem_rd  out  1  memory read strobe.
- busy  out  1  block owns the memory path.
- pc_out  out  32  new PC value.
- pc_wr  out  1  PC write enable, 1-cycle pulse.
- epc_out  out  32  EPC value.
- epc_wr  out  1  EPC write enable, 1-cycle pulse.
- done  out  1  1-cycle completion pulse.
- causa_err  out  1  1-cycle pulse: request with causa=00 rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE;
  - all outputs 0, including mem_addr, pc_out and epc_out;
  - internal wait counter and latched cause cleared.
- FSM states: IDLE, ADDR, WAIT, LOAD, DONE.
- IDLE:
  - req_excecao=1 and causa!=00: latch causa, set epc_reg=valorPC-4 (mod 2^32, wraps at 0→0xFFFFFFFC), go to ADDR.
  - req_excecao=1 and causa=00: causa_err pulses next cycle, stay IDLE.
  - Otherwise stay IDLE.
- ADDR:
  - busy=1, mem_rd=1;
  - mem_addr = VEC_* selected by the latched cause, zero-extended to 32 bits;
  - load counter = MEM_LATENCY; go to WAIT.
- WAIT:
  - busy=1, mem_rd=0, mem_addr held;
  - decrement counter; when it reaches 1, capture mem_data_in[7:0] on that edge and go to LOAD.
- LOAD:
  - busy=1;
  - pc_out = {24'b0, captured byte}, pc_wr=1;
  - epc_out = epc_reg, epc_wr=1;
  - go to DONE.
- DONE: busy=0, done=1, go to IDLE.
- Outside these states:
  - pc_wr, epc_wr, done and mem_rd are 0;
  - pc_out, epc_out and mem_addr hold their last value.
- Latency: request edge → pc_wr high is MEM_LATENCY+2 cycles (3 at default).
- req_excecao while not IDLE: ignored, never queued; cause and EPC are not overwritten.
- Request in the DONE cycle: ignored; it is accepted from IDLE on the following cycle.
- Reset mid-sequence: immediate return to IDLE. No partial pc_wr/epc_wr is ever issued after reset asserts.
- Upper 24 bits of mem_data_in are ignored.

Optional Feature:
- Macro name: EXC_CAUSE_REG_EN.
- When defined:
  - adds output causa_reg [1:0] holding the last accepted cause;
  - updated in the LOAD cycle; reset to 00;
  - readable by software via the datapath.
- When undefined: port absent, no register is implemented, and all other behaviour is identical.

Test Plan:
- Reset and idle: reset=0 mid-idle → all outputs 0; release with req_excecao=0 → outputs stay 0, busy=0.
- Overflow: valorPC=0x0000_0024, causa=10, req 1 cycle, MEM_LATENCY=1, memory returns 0x0000_0080 for addr 254.
  - Required: mem_rd=1 with mem_addr=254 in cycle 1.
  - Required: pc_wr=1, pc_out=0x80, epc_wr=1, epc_out=0x20 in cycle 3; done=1 in cycle 4.
- Invalid opcode and div-zero addressing:
  - causa=01 → mem_addr=253;
  - causa=11 → mem_addr=255;
  - mem_data_in=0xABCD_EF12 → pc_out=0x12.
- Rejection and collision:
  - causa=00 with req → causa_err pulse, busy stays 0;
  - second req (causa=11) during WAIT → ignored, epc_out and vector from the first request.
- Latency and wrap: MEM_LATENCY=4, valorPC=0 → pc_wr exactly 6 cycles after the request edge, epc_out=0xFFFF_FFFC.
- Reset mid-operation: reset=0 during WAIT → IDLE, no pc_wr/epc_wr; a new request after release completes normally.
